// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory: CPU port C, debug port D.
// Define DMARB_CPU_PRIO_EN for fixed CPU priority; default build is round-robin.
module dm_arbiter #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          C_Req,
  input  logic          C_Wr,
  input  logic [AW-1:0] C_Ad,
  input  logic [DW-1:0] C_WrData,
  output logic          C_Ack,
  output logic [DW-1:0] C_RdData,
  input  logic          D_Req,
  input  logic          D_Wr,
  input  logic [AW-1:0] D_Ad,
  input  logic [DW-1:0] D_WrData,
  output logic          D_Ack,
  output logic [DW-1:0] D_RdData,
  output logic [AW-1:0] Mem_Ad,
  output logic [DW-1:0] Mem_WrData,
  output logic          Mem_Wr,
  output logic          Mem_Rd,
  input  logic [DW-1:0] Mem_DM,
  output logic          Busy,
  output logic          Owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q;
  logic          owner_q;
  logic          wr_q;
  logic          busy_q;
  logic          c_ack_q;
  logic          d_ack_q;
  logic          mem_wr_q;
  logic          mem_rd_q;
  logic [AW-1:0] mem_ad_q;
  logic [DW-1:0] mem_wrdata_q;
  logic [DW-1:0] c_rddata_q;
  logic [DW-1:0] d_rddata_q;
`ifndef DMARB_CPU_PRIO_EN
  logic          last_q;
`endif

  logic          gnt_vld_d;
  logic          gnt_owner_d;
  logic          gnt_wr_d;
  logic [AW-1:0] gnt_ad_d;
  logic [DW-1:0] gnt_wrdata_d;

  // Winner selection, only consumed in IDLE
  always_comb begin
    gnt_vld_d = C_Req | D_Req;
`ifdef DMARB_CPU_PRIO_EN
    gnt_owner_d = !C_Req;
`else
    gnt_owner_d = (C_Req && D_Req) ? !last_q : D_Req;
`endif
    gnt_wr_d     = gnt_owner_d ? D_Wr     : C_Wr;
    gnt_ad_d     = gnt_owner_d ? D_Ad     : C_Ad;
    gnt_wrdata_d = gnt_owner_d ? D_WrData : C_WrData;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      c_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_ad_q     <= '0;
      mem_wrdata_q <= '0;
      c_rddata_q   <= '0;
      d_rddata_q   <= '0;
`ifndef DMARB_CPU_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      // Acks and strobes are single-cycle pulses unless set below
      c_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            state_q      <= ISSUE;
            busy_q       <= 1'b1;
            owner_q      <= gnt_owner_d;
            wr_q         <= gnt_wr_d;
            mem_ad_q     <= gnt_ad_d;
            mem_wrdata_q <= gnt_wrdata_d;
            mem_wr_q     <= gnt_wr_d;
            mem_rd_q     <= !gnt_wr_d;
          end
        end
        ISSUE: begin
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (owner_q) d_ack_q <= 1'b1;
          else         c_ack_q <= 1'b1;
          if (!wr_q) begin
            if (owner_q) d_rddata_q <= Mem_DM;
            else         c_rddata_q <= Mem_DM;
          end
`ifndef DMARB_CPU_PRIO_EN
          last_q <= owner_q;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign C_Ack      = c_ack_q;
  assign D_Ack      = d_ack_q;
  assign C_RdData   = c_rddata_q;
  assign D_RdData   = d_rddata_q;
  assign Mem_Ad     = mem_ad_q;
  assign Mem_WrData = mem_wrdata_q;
  assign Mem_Wr     = mem_wr_q;
  assign Mem_Rd     = mem_rd_q;
  assign Busy       = busy_q;
  assign Owner      = owner_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized two-port traffic against a memory model.
module tb_dm_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
`ifdef DMARB_CPU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          C_Req = 1'b0, C_Wr = 1'b0;
  logic [AW-1:0] C_Ad = '0;
  logic [DW-1:0] C_WrData = '0;
  logic          C_Ack;
  logic [DW-1:0] C_RdData;
  logic          D_Req = 1'b0, D_Wr = 1'b0;
  logic [AW-1:0] D_Ad = '0;
  logic [DW-1:0] D_WrData = '0;
  logic          D_Ack;
  logic [DW-1:0] D_RdData;
  logic [AW-1:0] Mem_Ad;
  logic [DW-1:0] Mem_WrData;
  logic          Mem_Wr, Mem_Rd;
  logic [DW-1:0] Mem_DM = '0;
  logic          Busy, Owner;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .C_Req(C_Req), .C_Wr(C_Wr), .C_Ad(C_Ad), .C_WrData(C_WrData),
    .C_Ack(C_Ack), .C_RdData(C_RdData),
    .D_Req(D_Req), .D_Wr(D_Wr), .D_Ad(D_Ad), .D_WrData(D_WrData),
    .D_Ack(D_Ack), .D_RdData(D_RdData),
    .Mem_Ad(Mem_Ad), .Mem_WrData(Mem_WrData), .Mem_Wr(Mem_Wr), .Mem_Rd(Mem_Rd),
    .Mem_DM(Mem_DM), .Busy(Busy), .Owner(Owner)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Single-port memory: write on the edge, registered read
  always @(posedge Clk) begin
    if (Mem_Wr) mem[Mem_Ad[5:0]] <= Mem_WrData;
    if (Mem_Rd) Mem_DM <= mem[Mem_Ad[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive(input int p, input logic req, input logic wr,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    if (p == 0) begin C_Req = req; C_Wr = wr; C_Ad = ad; C_WrData = wd; end
    else        begin D_Req = req; D_Wr = wr; D_Ad = ad; D_WrData = wd; end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? C_Ack : D_Ack;
  endfunction

  function automatic logic [DW-1:0] rd_of(input int p);
    return (p == 0) ? C_RdData : D_RdData;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        chk("ack_excl", 32'(C_Ack & D_Ack), 32'd0);
        chk("strobe_excl", 32'(Mem_Rd & Mem_Wr), 32'd0);
        chk("strobe_busy", 32'((Mem_Rd | Mem_Wr) & !Busy), 32'd0);
      end
    end
  endtask

  // One uncontended access: Ack exactly 3 cycles after the request edge
  task automatic txn(input int p, input logic wr, input logic [AW-1:0] ad,
                     input logic [DW-1:0] wd, input string tag);
    int lat;
    lat = 0;
    @(negedge Clk);
    drive(p, 1'b1, wr, ad, wd);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge Clk);
      if (ack_of(p)) lat = i;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    if (wr) begin
      chk({tag, "_mem"}, mem[ad[5:0]], wd);
      ref_mem[ad[5:0]] = wd;
    end else begin
      chk({tag, "_rd"}, rd_of(p), ref_mem[ad[5:0]]);
    end
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rnd(input int p, input int n);
    logic wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    int lat, lat_max;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      wr = 1'($urandom_range(0, 1));
      ad = AW'($urandom_range(0, 15));
      wd = $urandom;
      lat_max = (PRIO && p == 1) ? 40 : 6;
      drive(p, 1'b1, wr, ad, wd);
      lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
        @(negedge Clk);
        if (ack_of(p)) lat = i;
      end
      chk($sformatf("rnd%0d_lat", p), 32'(lat >= 3 && lat <= lat_max), 32'd1);
      if (lat != 0) begin
        if (wr) begin
          chk($sformatf("rnd%0d_wr", p), mem[ad[5:0]], wd);
          ref_mem[ad[5:0]] = wd;
        end else begin
          chk($sformatf("rnd%0d_rd", p), rd_of(p), ref_mem[ad[5:0]]);
        end
      end
      drive(p, 1'b0, ~wr, ad ^ AW'(5), ~wd);
    end
  endtask

  initial begin
    int last_port, exp_p, port, acks, prev, lat;
    fork
      monitor();
    join_none

    repeat (3) @(negedge Clk);
    chk("rst_cack", 32'(C_Ack), 32'd0);
    chk("rst_dack", 32'(D_Ack), 32'd0);
    chk("rst_memwr", 32'(Mem_Wr), 32'd0);
    chk("rst_memrd", 32'(Mem_Rd), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_owner", 32'(Owner), 32'd0);
    chk("rst_memad", 32'(Mem_Ad), 32'd0);
    chk("rst_memwd", Mem_WrData, 32'd0);
    chk("rst_crd", C_RdData, 32'd0);
    chk("rst_drd", D_RdData, 32'd0);
    Reset = 1'b0;
    mon_en = 1'b1;

    // C write 5
    @(negedge Clk);
    drive(0, 1'b1, 1'b1, 30'd5, 32'hDEADBEEF);
    @(negedge Clk);
    chk("w5_memwr", 32'(Mem_Wr), 32'd1);
    chk("w5_memrd", 32'(Mem_Rd), 32'd0);
    chk("w5_memad", 32'(Mem_Ad), 32'd5);
    chk("w5_memwd", Mem_WrData, 32'hDEADBEEF);
    chk("w5_busy", 32'(Busy), 32'd1);
    chk("w5_owner", 32'(Owner), 32'd0);
    @(negedge Clk);
    chk("w5_resp_memwr", 32'(Mem_Wr), 32'd0);
    chk("w5_resp_cack", 32'(C_Ack), 32'd0);
    @(negedge Clk);
    chk("w5_cack", 32'(C_Ack), 32'd1);
    chk("w5_dack", 32'(D_Ack), 32'd0);
    chk("w5_mem", mem[5], 32'hDEADBEEF);
    ref_mem[5] = 32'hDEADBEEF;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    chk("w5_cack_end", 32'(C_Ack), 32'd0);

    // C read 5
    drive(0, 1'b1, 1'b0, 30'd5, 32'h0);
    @(negedge Clk);
    chk("r5_memrd", 32'(Mem_Rd), 32'd1);
    chk("r5_memwr", 32'(Mem_Wr), 32'd0);
    chk("r5_memad", 32'(Mem_Ad), 32'd5);
    @(negedge Clk);
    chk("r5_memrd_end", 32'(Mem_Rd), 32'd0);
    @(negedge Clk);
    chk("r5_cack", 32'(C_Ack), 32'd1);
    chk("r5_data", C_RdData, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, '0, '0);

    txn(0, 1'b1, 30'd1, 32'h11111111, "pre1");
    txn(1, 1'b1, 30'd2, 32'h22222222, "pre2");
    txn(0, 1'b1, 30'd9, 32'h00001234, "pre9");
    txn(0, 1'b1, 30'd3, 32'h33333333, "pre3");
    last_port = 0;

    // Both ports reading continuously
    exp_p = PRIO ? 0 : (last_port ^ 1);
    acks = 0;
    prev = -1;
    @(negedge Clk);
    drive(0, 1'b1, 1'b0, 30'd1, '0);
    drive(1, 1'b1, 1'b0, 30'd2, '0);
    for (int i = 0; i < 30 && acks < 4; i++) begin
      @(negedge Clk);
      if (C_Ack || D_Ack) begin
        port = D_Ack ? 1 : 0;
        chk("cont_owner", 32'(port), 32'(exp_p));
        chk("cont_rd", rd_of(port), ref_mem[port == 1 ? 2 : 1]);
        if (prev >= 0) chk("cont_gap", 32'(cyc - prev), 32'd3);
        prev = cyc;
        last_port = port;
        exp_p = PRIO ? 0 : (port ^ 1);
        acks++;
      end
    end
    chk("cont_acks", 32'(acks), 32'd4);
    drive(0, 1'b0, 1'b0, '0, '0);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge Clk);
      if (D_Ack) lat = i;
    end
    chk("d_after_c_lat", 32'(lat), 32'd3);
    chk("d_after_c_rd", D_RdData, 32'h22222222);
    drive(1, 1'b0, 1'b0, '0, '0);

    // D write 9 aborted by Reset during ISSUE
    @(negedge Clk);
    drive(1, 1'b1, 1'b1, 30'd9, 32'h0BADF00D);
    @(negedge Clk);
    chk("abort_memwr", 32'(Mem_Wr), 32'd1);
    chk("abort_memad", 32'(Mem_Ad), 32'd9);
    Reset = 1'b1;
    #1;
    chk("abort_memwr_rst", 32'(Mem_Wr), 32'd0);
    chk("abort_busy_rst", 32'(Busy), 32'd0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("abort_no_dack", 32'(D_Ack), 32'd0);
    end
    chk("abort_mem9", mem[9], 32'h00001234);
    chk("abort_busy", 32'(Busy), 32'd0);
    txn(0, 1'b0, 30'd9, '0, "post_abort_rd");

    // Address change after grant is ignored
    @(negedge Clk);
    drive(0, 1'b1, 1'b0, 30'd3, '0);
    @(negedge Clk);
    drive(0, 1'b1, 1'b0, 30'd7, '0);
    chk("late_ad_memad", 32'(Mem_Ad), 32'd3);
    chk("late_ad_memrd", 32'(Mem_Rd), 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    chk("late_ad_cack", 32'(C_Ack), 32'd1);
    chk("late_ad_rd", C_RdData, 32'h33333333);
    drive(0, 1'b0, 1'b0, '0, '0);

    // Randomized two-port traffic over a 16-word window
    for (int a = 0; a < 16; a++)
      txn(a % 2, 1'b1, AW'(a), $urandom, "fill");
    fork
      rnd(0, 40);
      rnd(1, 40);
    join
    repeat (4) @(negedge Clk);
    chk("final_busy", 32'(Busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
